// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI encodings and the slave FSM state type.
package axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_WAIT,
    S_RD_RESP,
    S_WR_RESP
  } state_e;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 single-beat channel bundle between the core master and the SRAM slave.
interface axi_sram_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) ();
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  arvalid, arready;
    logic [3:0]            arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid, rready;
    logic [3:0]            rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    logic                  awvalid, awready;
    logic [3:0]            awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid, wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;

    logic                  bvalid, bready;
    logic [3:0]            bid;
    logic [1:0]            bresp;

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready,
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready
    );

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready,
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready
    );
endinterface

// File: rtl/axi_delay_counter.sv
// 4-bit response-delay counter; AXI_SRAM_RAND_DELAY_EN swaps the fixed load value
// for the low nibble of an 8-bit LFSR that steps once per accepted transaction.
module axi_delay_counter #(
    parameter logic [3:0] LAT_CYCLES = 4'd1,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load,
    input  logic       dec,
    output logic [3:0] value,
    output logic       done
);
    logic [3:0] load_val;

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;
    logic       fb;
    logic [3:0] unused_lat;

    // Fibonacci taps 8,6,5,4
    assign fb         = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign load_val   = lfsr[3:0];
    assign unused_lat = LAT_CYCLES;

    always_ff @(posedge clk_i) begin
        if (rst_i)     lfsr <= LFSR_SEED;
        else if (load) lfsr <= {lfsr[6:0], fb};
    end
`else
    logic [7:0] unused_seed;

    assign load_val    = LAT_CYCLES;
    assign unused_seed = LFSR_SEED;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i)     value <= 4'd0;
        else if (load) value <= load_val;
        else if (dec)  value <= value - 4'd1;
    end

    assign done = (value == 4'd0);
endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI4 SRAM slave with programmable response latency.
// Build with AXI_SRAM_RAND_DELAY_EN for LFSR-driven random delays (0..15).
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h8000_0000,
    parameter int                    MEM_WORDS  = 4096,
    parameter int                    LAT_CYCLES = 1,
    parameter logic [7:0]            LFSR_SEED  = 8'hA5
) (
    input logic      clk_i,
    input logic      rst_i,
    axi_sram_if.slave bus
);
    localparam int LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0] MEM_END =
        {1'b0, MEM_BASE} + (ADDR_WIDTH + 1)'(MEM_WORDS * STRB_WIDTH);

    state_e state, state_nxt;
    logic   rd_acc, wr_acc, rd_fire, mem_we;
    logic   cnt_load, cnt_dec, cnt_done;
    logic [3:0] cnt_value;

    logic [3:0]            id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    resp_e                 resp_q;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      idx;
    logic                  in_range, err;
    logic                  unused_bits;

    // Range check is done one bit wider so MEM_BASE+size cannot wrap.
    assign in_range = ({1'b0, addr_q} >= {1'b0, MEM_BASE}) && ({1'b0, addr_q} < MEM_END);
    assign err      = !in_range || (len_q != 8'd0);
    assign offset   = addr_q - MEM_BASE;
    assign idx      = offset[LSB +: IDX_W];

    assign unused_bits = ^{offset, bus.arsize, bus.arburst, bus.awsize, bus.awburst,
                           bus.wlast, cnt_value};

    axi_delay_counter #(
        .LAT_CYCLES(4'(LAT_CYCLES)),
        .LFSR_SEED (LFSR_SEED)
    ) u_delay (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .load (cnt_load),
        .dec  (cnt_dec),
        .value(cnt_value),
        .done (cnt_done)
    );

    assign cnt_load = rd_acc | wr_acc;
    assign cnt_dec  = (state == S_RD_WAIT || state == S_WR_WAIT) && !cnt_done;

    always_comb begin
        state_nxt   = state;
        bus.arready = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        rd_acc      = 1'b0;
        wr_acc      = 1'b0;
        rd_fire     = 1'b0;
        mem_we      = 1'b0;
        case (state)
            S_IDLE: begin
                // write wins a simultaneous AR/AW+W tie
                wr_acc      = bus.awvalid & bus.wvalid;
                rd_acc      = bus.arvalid & ~wr_acc;
                bus.awready = wr_acc;
                bus.wready  = wr_acc;
                bus.arready = rd_acc;
                if (wr_acc)      state_nxt = S_WR_WAIT;
                else if (rd_acc) state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: if (cnt_done) begin
                rd_fire   = 1'b1;
                state_nxt = S_RD_RESP;
            end
            S_WR_WAIT: if (cnt_done) begin
                mem_we    = 1'b1;
                state_nxt = S_WR_RESP;
            end
            S_RD_RESP: if (bus.rready) state_nxt = S_IDLE;
            S_WR_RESP: if (bus.bready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            state <= state_nxt;
            if (rd_acc) begin
                id_q   <= bus.arid;
                addr_q <= bus.araddr;
                len_q  <= bus.arlen;
            end
            if (wr_acc) begin
                id_q    <= bus.awid;
                addr_q  <= bus.awaddr;
                len_q   <= bus.awlen;
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
            end
            if (rd_fire) rdata_q <= err ? '0 : mem[idx];
            if (rd_fire || mem_we) resp_q <= err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i && !err) begin
            for (int b = 0; b < STRB_WIDTH; b++)
                if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end

    assign bus.rvalid = (state == S_RD_RESP);
    assign bus.rlast  = (state == S_RD_RESP);
    assign bus.rid    = id_q;
    assign bus.rdata  = rdata_q;
    assign bus.rresp  = resp_q;
    assign bus.bvalid = (state == S_WR_RESP);
    assign bus.bid    = id_q;
    assign bus.bresp  = resp_q;
endmodule
